// File: rtl/inst_fetch_axi_pkg.sv
// rtl/inst_fetch_axi_pkg.sv - shared widths and AXI/fetch constants for the instruction fetch stage
package inst_fetch_axi_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] ARPROT_INST   = 3'b100;

  localparam logic [1:0] FETCH_ERR_NONE  = 2'b00;
  localparam logic [1:0] FETCH_ERR_BUS   = 2'b01;
  localparam logic [1:0] FETCH_ERR_ALIGN = 2'b10;

endpackage

// File: rtl/inst_fetch_axi.sv
// rtl/inst_fetch_axi.sv - IF stage issuing one AXI4-Lite read per instruction
// Single outstanding read; flushes mark the open transaction for discard instead of breaking the handshake.
module inst_fetch_axi
  import inst_fetch_axi_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_ADDR_BUS-1:0] pc,
  input  logic                     ce,
  input  logic [5:0]               stall,
  input  logic                     flush,
  output logic                     stallreq_o,
  output logic [INST_DATA_BUS-1:0] inst_o,
  output logic [INST_ADDR_BUS-1:0] inst_pc_o,
  output logic                     inst_valid_o,
  output logic [1:0]               inst_err_o,
  output logic [INST_ADDR_BUS-1:0] araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [INST_DATA_BUS-1:0] rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_DATA = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  fetch_state_e state;
  logic         discard;

  // Only the IF/ID hold bit matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign arprot = ARPROT_INST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH_IDLE;
      discard      <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      araddr       <= '0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      inst_err_o   <= FETCH_ERR_NONE;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (ce && !flush) begin
            inst_pc_o <= pc;
            if (pc[1:0] == 2'b00) begin
              araddr  <= pc;
              arvalid <= 1'b1;
              state   <= FETCH_ADDR;
            end else begin
              inst_o       <= '0;
              inst_err_o   <= FETCH_ERR_ALIGN;
              inst_valid_o <= 1'b1;
              state        <= FETCH_HOLD;
            end
          end
        end
        FETCH_ADDR: begin
          if (flush) discard <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= FETCH_DATA;
          end
        end
        FETCH_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            // A flush coinciding with the data beat kills the word just like an earlier one.
            if (discard || flush) begin
              discard <= 1'b0;
              state   <= FETCH_IDLE;
            end else begin
              inst_o       <= (rresp == AXI_RESP_OKAY) ? rdata : '0;
              inst_err_o   <= (rresp == AXI_RESP_OKAY) ? FETCH_ERR_NONE : FETCH_ERR_BUS;
              inst_valid_o <= 1'b1;
              state        <= FETCH_HOLD;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (flush || !stall[1]) begin
            inst_o       <= '0;
            inst_err_o   <= FETCH_ERR_NONE;
            inst_valid_o <= 1'b0;
            state        <= FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      FETCH_IDLE: stallreq_o = ce & ~flush;
      FETCH_ADDR: stallreq_o = 1'b1;
      FETCH_DATA: stallreq_o = 1'b1;
      default:    stallreq_o = 1'b0;
    endcase
    if (!rst) stallreq_o = 1'b0;
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// tb/tb_inst_fetch_axi.sv - bench for inst_fetch_axi
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        ce = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        stallreq_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic [1:0]  inst_err_o;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;

  inst_fetch_axi dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .stallreq_o(stallreq_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .inst_err_o(inst_err_o),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] next_pc();
    logic [31:0] r;
    r = $urandom;
    if (r[2:0] == 3'd0) return {20'h0, r[15:4]};
    return {18'h0, r[15:4], 2'b00};
  endfunction

  task automatic defaults();
    ce = 0; flush = 0; stall = '0; arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Zero-wait fetch; returns at the negedge of the first HOLD cycle with idle inputs.
  task automatic fetch_to_hold(input logic [31:0] a, input logic [31:0] w, input logic [1:0] r);
    cyc(); defaults(); pc = a; ce = 1; arready = 1;
    cyc();
    cyc(); arready = 0; rvalid = 1; rdata = w; rresp = r;
    cyc(); defaults();
  endtask

  task automatic test_reset();
    rst = 0; defaults(); pc = 32'h1234; ce = 1;
    cyc(); #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %0b exp 0", stallreq_o); end
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL reset_handshake: arvalid=%0b rready=%0b exp 0/0", arvalid, rready); end
    checks++; if (araddr !== 32'h0 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_addr: araddr=%h inst_pc=%h exp 0", araddr, inst_pc_o); end
    checks++; if (inst_o !== 32'h0 || inst_valid_o !== 1'b0 || inst_err_o !== 2'b00) begin errors++; $display("FAIL reset_inst: inst=%h valid=%0b err=%0b exp 0/0/0", inst_o, inst_valid_o, inst_err_o); end
    checks++; if (arprot !== 3'b100) begin errors++; $display("FAIL reset_arprot: got %b exp 100", arprot); end
    ce = 0;
    cyc(); rst = 1;
  endtask

  task automatic test_basic_fetch();
    cyc(); defaults(); pc = 32'h0; ce = 1; arready = 1; #1;
    checks++; if (stallreq_o !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL basic_t0: stallreq=%0b arvalid=%0b exp 1/0", stallreq_o, arvalid); end
    cyc(); #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h0) begin errors++; $display("FAIL basic_t1_ar: arvalid=%0b araddr=%h exp 1/0", arvalid, araddr); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h2401_0005; #1;
    checks++; if (rready !== 1'b1 || arvalid !== 1'b0 || stallreq_o !== 1'b1) begin errors++; $display("FAIL basic_t2: rready=%0b arvalid=%0b stallreq=%0b exp 1/0/1", rready, arvalid, stallreq_o); end
    cyc(); defaults(); #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h2401_0005) begin errors++; $display("FAIL basic_t3_word: valid=%0b inst=%h exp 1/24010005", inst_valid_o, inst_o); end
    checks++; if (stallreq_o !== 1'b0 || inst_err_o !== 2'b00 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL basic_t3_side: stallreq=%0b err=%0b pc=%h exp 0/0/0", stallreq_o, inst_err_o, inst_pc_o); end
    cyc(); #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL basic_t4_idle: valid=%0b inst=%h exp 0/0", inst_valid_o, inst_o); end
  endtask

  task automatic test_wait_states();
    cyc(); defaults(); pc = 32'h40; ce = 1; #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL wait_t0_stallreq: got %0b exp 1", stallreq_o); end
    for (int t = 1; t <= 7; t++) begin
      cyc(); arready = (t == 3); rvalid = (t == 7); rdata = 32'h8c22_0004; #1;
      checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL wait_stallreq_t%0d: got %0b exp 1", t, stallreq_o); end
      if (t <= 3) begin
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h40 || rready !== 1'b0) begin errors++; $display("FAIL wait_addr_t%0d: arvalid=%0b araddr=%h rready=%0b exp 1/40/0", t, arvalid, araddr, rready); end
      end else begin
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL wait_data_t%0d: arvalid=%0b rready=%0b exp 0/1", t, arvalid, rready); end
      end
    end
    cyc(); defaults(); #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h8c22_0004 || stallreq_o !== 1'b0) begin errors++; $display("FAIL wait_t8: valid=%0b inst=%h stallreq=%0b exp 1/8c220004/0", inst_valid_o, inst_o, stallreq_o); end
    cyc();
  endtask

  task automatic test_flush_data();
    cyc(); defaults(); pc = 32'h100; ce = 1;
    cyc(); arready = 1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h100) begin errors++; $display("FAIL flush_t1: arvalid=%0b araddr=%h exp 1/100", arvalid, araddr); end
    cyc(); arready = 0; flush = 1; #1;
    checks++; if (rready !== 1'b1 || stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_t2: rready=%0b stallreq=%0b exp 1/1", rready, stallreq_o); end
    cyc(); flush = 0; pc = 32'h200; #1;
    checks++; if (rready !== 1'b1 || stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_t3: rready=%0b stallreq=%0b exp 1/1", rready, stallreq_o); end
    cyc(); rvalid = 1; rdata = 32'hdead_beef; #1;
    checks++; if (rready !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_t4: rready=%0b valid=%0b exp 1/0", rready, inst_valid_o); end
    cyc(); rvalid = 0; #1;
    checks++; if (inst_valid_o !== 1'b0 || arvalid !== 1'b0 || stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_t5_idle: valid=%0b arvalid=%0b stallreq=%0b exp 0/0/1", inst_valid_o, arvalid, stallreq_o); end
    cyc(); arready = 1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h200) begin errors++; $display("FAIL flush_t6_refetch: arvalid=%0b araddr=%h exp 1/200", arvalid, araddr); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h0000_0200;
    cyc(); defaults(); #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0200 || inst_pc_o !== 32'h200) begin errors++; $display("FAIL flush_t8_word: valid=%0b inst=%h pc=%h exp 1/200/200", inst_valid_o, inst_o, inst_pc_o); end
    cyc();
  endtask

  task automatic test_stall_hold();
    fetch_to_hold(32'h300, 32'hcafe_0300, 2'b00);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      stall = 6'b000010; ce = 1; pc = 32'h304; #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hcafe_0300) begin errors++; $display("FAIL stall_hold_%0d: valid=%0b inst=%h exp 1/cafe0300", k, inst_valid_o, inst_o); end
      checks++; if (arvalid !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL stall_bus_%0d: arvalid=%0b stallreq=%0b exp 0/0", k, arvalid, stallreq_o); end
    end
    cyc(); stall = '0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hcafe_0300) begin errors++; $display("FAIL stall_release: valid=%0b inst=%h exp 1/cafe0300", inst_valid_o, inst_o); end
    cyc(); ce = 0; #1;
    checks++; if (inst_valid_o !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL stall_consumed: valid=%0b arvalid=%0b exp 0/0", inst_valid_o, arvalid); end
    fetch_to_hold(32'h400, 32'h1111_0400, 2'b00);
    stall = 6'b000010; flush = 1; #1;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL flushstall_pre: valid=%0b exp 1", inst_valid_o); end
    cyc(); defaults(); #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL flushstall_drop: valid=%0b inst=%h exp 0/0", inst_valid_o, inst_o); end
  endtask

  task automatic test_errors();
    fetch_to_hold(32'h500, 32'h1234_5678, 2'b10);
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0 || inst_err_o !== 2'b01) begin errors++; $display("FAIL buserr: valid=%0b inst=%h err=%b exp 1/0/01", inst_valid_o, inst_o, inst_err_o); end
    cyc(); #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_err_o !== 2'b00) begin errors++; $display("FAIL buserr_clear: valid=%0b err=%b exp 0/00", inst_valid_o, inst_err_o); end
    cyc(); defaults(); pc = 32'h102; ce = 1; #1;
    checks++; if (stallreq_o !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL align_t0: stallreq=%0b arvalid=%0b exp 1/0", stallreq_o, arvalid); end
    cyc(); ce = 0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0 || inst_err_o !== 2'b10 || inst_pc_o !== 32'h102) begin errors++; $display("FAIL align_t1: valid=%0b inst=%h err=%b pc=%h exp 1/0/10/102", inst_valid_o, inst_o, inst_err_o, inst_pc_o); end
    checks++; if (arvalid !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL align_t1_bus: arvalid=%0b stallreq=%0b exp 0/0", arvalid, stallreq_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc(); defaults(); pc = 32'h600; ce = 1;
    cyc(); #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: arvalid=%0b exp 1", arvalid); end
    #1 rst = 0; #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 32'h0) begin errors++; $display("FAIL rstmid_bus: arvalid=%0b rready=%0b araddr=%h exp 0/0/0", arvalid, rready, araddr); end
    checks++; if (stallreq_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL rstmid_out: stallreq=%0b valid=%0b pc=%h exp 0/0/0", stallreq_o, inst_valid_o, inst_pc_o); end
    cyc(); rst = 1; ce = 0;
    cyc(); #1;
    checks++; if (arvalid !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: arvalid=%0b stallreq=%0b exp 0/0", arvalid, stallreq_o); end
  endtask

  // Transaction-level model: idle / bus transaction open / word presented.
  task automatic test_random();
    typedef enum {M_IDLE, M_BUS, M_WORD} mphase_t;
    mphase_t     ph = M_IDLE;
    logic        ar_done = 0, killed = 0;
    logic [31:0] m_addr = '0, w_inst = '0, w_pc = '0, cur_pc;
    logic [1:0]  w_err = '0;
    int          delivered = 0;
    cur_pc = next_pc();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      flush   = ($urandom_range(0, 15) == 0);
      stall   = 6'($urandom);
      ce      = ($urandom_range(0, 7) != 0);
      pc      = cur_pc;
      arready = ($urandom_range(0, 2) == 0);
      rvalid  = (ph == M_BUS && ar_done) ? ($urandom_range(0, 2) == 0) : 1'b0;
      rresp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdata   = rvalid ? mem_word(m_addr) : $urandom;
      #1;
      if (inst_valid_o === 1'b0 && inst_o !== 32'h0) begin checks++; errors++; $display("FAIL rnd_nop_%0d: inst=%h exp 0", n, inst_o); end
      case (ph)
        M_IDLE: begin
          checks++; if (stallreq_o !== (ce & ~flush)) begin errors++; $display("FAIL rnd_idle_stallreq_%0d: got %0b exp %0b", n, stallreq_o, ce & ~flush); end
          checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_idle_%0d: arvalid=%0b rready=%0b valid=%0b exp 0/0/0", n, arvalid, rready, inst_valid_o); end
          if (ce && !flush) begin
            if (pc[1:0] == 2'b00) begin ph = M_BUS; m_addr = pc; ar_done = 0; killed = 0; end
            else begin ph = M_WORD; w_inst = 32'h0; w_err = 2'b10; w_pc = pc; end
          end
        end
        M_BUS: begin
          checks++; if (stallreq_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_bus_%0d: stallreq=%0b valid=%0b exp 1/0", n, stallreq_o, inst_valid_o); end
          if (!ar_done) begin
            checks++; if (arvalid !== 1'b1 || araddr !== m_addr || rready !== 1'b0) begin errors++; $display("FAIL rnd_ar_%0d: arvalid=%0b araddr=%h rready=%0b exp 1/%h/0", n, arvalid, araddr, rready, m_addr); end
          end else begin
            checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL rnd_r_%0d: arvalid=%0b rready=%0b exp 0/1", n, arvalid, rready); end
          end
          killed = killed | flush;
          if (!ar_done) begin
            if (arready) ar_done = 1;
          end else if (rvalid) begin
            if (killed) ph = M_IDLE;
            else begin
              ph = M_WORD; w_pc = m_addr;
              w_inst = (rresp == 2'b00) ? mem_word(m_addr) : 32'h0;
              w_err  = (rresp == 2'b00) ? 2'b00 : 2'b01;
            end
          end
        end
        default: begin
          checks++; if (inst_valid_o !== 1'b1 || inst_o !== w_inst || inst_err_o !== w_err || inst_pc_o !== w_pc) begin errors++; $display("FAIL rnd_word_%0d: valid=%0b inst=%h err=%b pc=%h exp 1/%h/%b/%h", n, inst_valid_o, inst_o, inst_err_o, inst_pc_o, w_inst, w_err, w_pc); end
          checks++; if (stallreq_o !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL rnd_word_bus_%0d: stallreq=%0b arvalid=%0b rready=%0b exp 0/0/0", n, stallreq_o, arvalid, rready); end
          if (flush) ph = M_IDLE;
          else if (!stall[1]) begin ph = M_IDLE; delivered++; cur_pc = next_pc(); end
        end
      endcase
      if (flush) cur_pc = next_pc();
    end
    checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_delivered: got %0d exp >=50", delivered); end
    cyc(); defaults();
  endtask

  initial begin
    defaults();
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_flush_data();
    test_stall_hold();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Instruction-fetch stage between the PC register and the IF/ID pipeline register. Takes the current `pc`/`ce` from the PC stage and issues one AXI4-Lite read per instruction on the instruction bus. It presents the returned word to IF/ID and raises a stall request to the pipeline controller until the word is available. Only one transaction is outstanding at a time; pipeline flushes are honoured without violating AXI handshakes.

## Interface
- No parameters. Widths come from `INST_ADDR_BUS` (31:0) and `INST_DATA_BUS` (31:0).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pc`  in  32  fetch address from the PC stage.
- `ce`  in  1  fetch enable from the PC stage; 1 = fetch allowed.
- `stall`  in  6  pipeline stall vector; `stall[1]`=1 means IF/ID holds.
- `flush`  in  1  pipeline flush; the PC stage loads `new_pc` on the same edge.
- `stallreq_o`  out  1  request to the controller to freeze the PC and IF stages.
- `inst_o`  out  32  fetched instruction; 0 (nop) whenever `inst_valid_o`=0.
- `inst_pc_o`  out  32  address of the word on `inst_o`.
- `inst_valid_o`  out  1  `inst_o` is a valid instruction for IF/ID.
- `inst_err_o`  out  2  00 none, 01 bus error (`rresp`≠OKAY), 10 misaligned PC.
- `araddr`  out  32  AXI read address.
- `arprot`  out  3  constant 3'b100 (instruction access).
- `arvalid`  out  1  AXI read-address valid.
- `arready`  in  1  AXI read-address ready.
- `rdata`  in  32  AXI read data.
- `rresp`  in  2  AXI read response.
- `rvalid`  in  1  AXI read-data valid.
- `rready`  out  1  AXI read-data ready.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD. There is also a `discard` flag.
- **IDLE**
  - If `ce`=1, `flush`=0 and `pc[1:0]`=0: latch `pc` into `araddr`/`inst_pc_o`, set `arvalid`=1, go to ADDR.
  - If `ce`=1, `flush`=0 and `pc[1:0]`≠0: no bus request. Latch `pc`, set inst=0 and err=10, go to HOLD.
  - Otherwise stay in IDLE.
- **ADDR:** hold `arvalid`=1 and keep `araddr` stable until `arready`=1. On that edge, drop `arvalid`, set `rready`=1, go to DATA.
- **DATA:** on `rvalid`=1, drop `rready`.
  - If `discard`=1: clear `discard`, go to IDLE.
  - Otherwise latch `rdata` (or 0 if `rresp`≠2'b00) and err (01 if `rresp`≠2'b00, else 00), go to HOLD.
- **HOLD:** `inst_valid_o`=1.
  - If `flush`=1: go to IDLE, invalidating the word.
  - Else if `stall[1]`=0: the word is consumed this cycle; go to IDLE.
  - Else stay in HOLD.
- **`stallreq_o`** (combinational):
  - IDLE: `ce & ~flush`.
  - ADDR/DATA: 1.
  - HOLD: 0.
  - Forced to 0 while `rst`=0.
- **Flush in ADDR or DATA:** set `discard`. The transaction still completes per AXI rules: `arvalid` never drops before `arready`, and `rready` stays high until `rvalid`. The returned data is dropped. `stallreq_o` stays 1 until completion, so the flushed `new_pc` is fetched next.
- **Flush in IDLE:** no request that cycle; the next IDLE cycle fetches `new_pc`.

## Timing
- Reset values:
  - State IDLE, `discard`=0.
  - `arvalid`=0, `rready`=0, `araddr`=0.
  - `inst_o`=0, `inst_pc_o`=0, `inst_valid_o`=0, `inst_err_o`=00, `stallreq_o`=0.
  - `arprot`=3'b100.
- Asserting `rst` mid-transaction aborts to IDLE immediately; the AXI slave shares the reset.
- Minimum latency with `arready` and `rvalid` both high on first sight:
  - IDLE (T0) → ADDR (T1) → DATA (T2) → HOLD (T3).
  - The word is visible at T3; the PC advances at the T3→T4 edge.
  - Throughput: 4 cycles per instruction.
- Each extra cycle of `arready`=0 or `rvalid`=0 adds one cycle in ADDR or DATA respectively.
- The misaligned path takes 2 cycles (IDLE → HOLD).
- `flush` and `stall[1]` together in HOLD: flush wins, and the word is not delivered.
- `rvalid` arriving in the same cycle as `flush` in DATA: the word is discarded, state goes to IDLE.

## Structure
- Add to the shared `define/axi.vh`:
  - `AXI_RESP_OKAY` (2'b00).
  - `ARPROT_INST` (3'b100).
  - Fetch error codes `FETCH_ERR_NONE`/`BUS`/`ALIGN`.
- State encodings are local `localparam`s.
- No sub-module is needed: a single FSM module of about 150–250 lines.

## Test plan
- **Basic fetch:** `pc`=0x00000000, `ce`=1, slave with zero wait and `rdata`=0x24010005 → `arvalid` at T1, `inst_valid_o`=1 with `inst_o`=0x24010005 at T3, `stallreq_o`=0 at T3.
- **Wait states:** `arready` delayed 2 cycles, `rvalid` delayed 3 cycles → `araddr`/`arvalid` stable throughout, word at T8, `stallreq_o`=1 from T0 to T7.
- **Flush in DATA:** fetch 0x100 with `flush`=1 at T2 and `rvalid` at T4 (`rdata`=0xDEADBEEF) → word never valid, then fetch of `new_pc`=0x200 begins in IDLE at T5.
- **Stall hold:** `stall[1]`=1 for 3 cycles in HOLD → `inst_o`/`inst_valid_o` held, no new `arvalid` until `stall[1]`=0.
- **Errors:** `rresp`=2'b10 → `inst_o`=0, `inst_err_o`=01. `pc`=0x102 → no `arvalid`, HOLD at T1 with `inst_err_o`=10.
- **Reset mid-transaction:** `rst`=0 while in ADDR → `arvalid`=0 asynchronously, all outputs at their reset values.
